// File: rtl/reg_bank_param_if.sv
// Simple req/ack register-bus: one request per cycle, one-cycle ack pulse back.
interface reg_bank_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
);
  logic                  req;
  logic                  wr;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  ack;
  logic                  err;
  logic [DATA_W-1:0]     rdata;

  modport master (
    output req, wr, addr, wdata, wstrb,
    input  ack, err, rdata
  );

  modport slave (
    input  req, wr, addr, wdata, wstrb,
    output ack, err, rdata
  );
endinterface

// File: rtl/reg_bank_param.sv
// Parametrised register bank with byte-strobed writes, registered reads,
// a one-register-per-cycle clear sweep and a flat tap of all registers.
module reg_bank_param #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  reg_bank_param_if.slave         bus,
  input  logic                    clr,
  output logic                    busy,
  output logic [DEPTH*DATA_W-1:0] d_out
);

  localparam int                NB       = DATA_W / 8;
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   cnt_reg, cnt_next;
  logic                accept;
  logic                in_range;
  logic                wr_en;
  logic [DATA_W-1:0]   rd_sel;

  // Addresses beyond DEPTH (possible when DEPTH is not a power of two) are flagged.
  assign in_range = ({1'b0, bus.addr} < DEPTH_L);
  assign wr_en    = accept && bus.wr && in_range;
  assign busy     = (state_reg == CLEAR);

  // State and sweep counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic: clr wins over req in IDLE; everything is ignored while sweeping.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (clr) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end else if (bus.req) begin
          accept = 1'b1;
        end
      end
      CLEAR: begin
        if (cnt_reg == LAST_IDX) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // One storage register per index; cleared by the sweep or byte-written by the bus.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
      logic [DATA_W-1:0] q;
      logic              hit;
      logic              zap;

      assign hit = wr_en && (bus.addr == ADDR_W'(gi));
      assign zap = busy && (cnt_reg == ADDR_W'(gi));

      // Register storage with per-byte write enables.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          q <= '0;
        end else if (zap) begin
          q <= '0;
        end else if (hit) begin
          for (int b = 0; b < NB; b++) begin
            if (bus.wstrb[b]) q[8*b +: 8] <= bus.wdata[8*b +: 8];
          end
        end
      end

      assign d_out[gi*DATA_W +: DATA_W] = q;
    end
  endgenerate

  // Read mux; unmatched (out-of-range) addresses read as zero.
  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (bus.addr == ADDR_W'(k)) rd_sel = d_out[k*DATA_W +: DATA_W];
    end
  end

  // Response registers: ack/err pulse once per accepted request, rdata holds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.ack   <= 1'b0;
      bus.err   <= 1'b0;
      bus.rdata <= '0;
    end else begin
      bus.ack <= accept;
      bus.err <= accept && !in_range;
      if (accept && !bus.wr) bus.rdata <= rd_sel;
    end
  end

endmodule

// File: tb/tb_reg_bank_param.sv
// Directed bench for reg_bank_param: an 8-deep bank and a 6-deep bank.
module tb_reg_bank_param;

  logic clk;
  logic reset_n;
  logic clr8, clr6;
  logic busy8, busy6;
  logic [255:0] d_out8;
  logic [191:0] d_out6;

  int total = 0;
  int bad   = 0;

  logic [31:0] m8 [8];
  logic [31:0] m6 [6];

  reg_bank_param_if #(.DATA_W(32), .ADDR_W(3)) bus8 ();
  reg_bank_param_if #(.DATA_W(32), .ADDR_W(3)) bus6 ();

  reg_bank_param #(.DATA_W(32), .DEPTH(8), .ADDR_W(3)) dut8 (
    .clk(clk), .reset_n(reset_n), .bus(bus8.slave),
    .clr(clr8), .busy(busy8), .d_out(d_out8)
  );

  reg_bank_param #(.DATA_W(32), .DEPTH(6), .ADDR_W(3)) dut6 (
    .clk(clk), .reset_n(reset_n), .bus(bus6.slave),
    .clr(clr6), .busy(busy6), .d_out(d_out6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-16s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [255:0] flat8();
    logic [255:0] f;
    f = '0;
    for (int k = 0; k < 8; k++) f[k*32 +: 32] = m8[k];
    return f;
  endfunction

  function automatic logic [255:0] flat6();
    logic [255:0] f;
    f = '0;
    for (int k = 0; k < 6; k++) f[k*32 +: 32] = m6[k];
    return f;
  endfunction

  task automatic drive8(input logic rq, input logic w, input logic [2:0] a,
                        input logic [31:0] d, input logic [3:0] s);
    bus8.req = rq; bus8.wr = w; bus8.addr = a; bus8.wdata = d; bus8.wstrb = s;
  endtask

  task automatic drive6(input logic rq, input logic w, input logic [2:0] a,
                        input logic [31:0] d, input logic [3:0] s);
    bus6.req = rq; bus6.wr = w; bus6.addr = a; bus6.wdata = d; bus6.wstrb = s;
  endtask

  initial begin
    reset_n = 1'b0;
    clr8 = 1'b0; clr6 = 1'b0;
    drive8(1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
    drive6(1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
    for (int k = 0; k < 8; k++) m8[k] = 32'h0;
    for (int k = 0; k < 6; k++) m6[k] = 32'h0;
    step(); step();

    // Reset state
    check("rst_busy", {255'd0, busy8}, 256'd0);
    check("rst_ack",  {255'd0, bus8.ack}, 256'd0);
    check("rst_dout", d_out8, 256'd0);
    reset_n = 1'b1;
    step();

    // Full write then read of addr 3
    drive8(1'b1, 1'b1, 3'd3, 32'hDEADBEEF, 4'hF);
    step();
    m8[3] = 32'hDEADBEEF;
    check("wr3_ack",  {254'd0, bus8.ack, bus8.err}, 256'd2);
    check("wr3_dout", {224'd0, d_out8[127:96]}, {224'd0, 32'hDEADBEEF});
    drive8(1'b1, 1'b0, 3'd3, 32'h0, 4'h0);
    step();
    check("rd3_ack",   {254'd0, bus8.ack, bus8.err}, 256'd2);
    check("rd3_rdata", {224'd0, bus8.rdata}, {224'd0, 32'hDEADBEEF});
    drive8(1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
    step();
    check("idle_ack",  {255'd0, bus8.ack}, 256'd0);
    check("rd_hold",   {224'd0, bus8.rdata}, {224'd0, 32'hDEADBEEF});

    // Byte strobes on addr 2
    drive8(1'b1, 1'b1, 3'd2, 32'h11223344, 4'hF);
    step();
    drive8(1'b1, 1'b1, 3'd2, 32'hAABBCCDD, 4'b0101);
    step();
    m8[2] = 32'h11BB33DD;
    check("strb_ack",  {255'd0, bus8.ack}, 256'd1);
    check("strb_dout", d_out8, flat8());
    drive8(1'b1, 1'b1, 3'd2, 32'hFFFFFFFF, 4'h0);
    step();
    check("strb0_ack",  {255'd0, bus8.ack}, 256'd1);
    check("strb0_dout", d_out8, flat8());

    // Fill all, then sweep with a write attempted throughout
    for (int k = 0; k < 8; k++) begin
      drive8(1'b1, 1'b1, 3'(k), 32'hA5000000 + 32'(k * 17 + 1), 4'hF);
      step();
      m8[k] = 32'hA5000000 + 32'(k * 17 + 1);
    end
    drive8(1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
    step();
    check("fill_dout", d_out8, flat8());
    clr8 = 1'b1;
    step();
    clr8 = 1'b0;
    drive8(1'b1, 1'b1, 3'd5, 32'hFFFFFFFF, 4'hF);
    for (int c = 0; c < 8; c++) begin
      check($sformatf("sw_busy%0d", c), {255'd0, busy8}, 256'd1);
      check($sformatf("sw_ack%0d", c),  {255'd0, bus8.ack}, 256'd0);
      step();
      m8[c] = 32'h0;
      check($sformatf("sw_dout%0d", c), d_out8, flat8());
    end
    drive8(1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
    check("sw_done",     {255'd0, busy8}, 256'd0);
    check("sw_done_ack", {255'd0, bus8.ack}, 256'd0);
    step();

    // clr and req in the same cycle: sweep wins, no ack
    drive8(1'b1, 1'b1, 3'd1, 32'h00000055, 4'hF);
    step();
    m8[1] = 32'h55;
    check("pre_clr", d_out8, flat8());
    clr8 = 1'b1;
    drive8(1'b1, 1'b1, 3'd1, 32'h00000077, 4'hF);
    step();
    clr8 = 1'b0;
    drive8(1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
    check("cr_ack",  {255'd0, bus8.ack}, 256'd0);
    check("cr_busy", {255'd0, busy8}, 256'd1);
    for (int c = 0; c < 8; c++) step();
    m8[1] = 32'h0;
    check("cr_done", {255'd0, busy8}, 256'd0);
    check("cr_dout", d_out8, flat8());

    // DEPTH=6: in-range access, then out-of-range read and write
    drive6(1'b1, 1'b1, 3'd0, 32'h0000CAFE, 4'hF);
    step();
    m6[0] = 32'hCAFE;
    drive6(1'b1, 1'b0, 3'd0, 32'h0, 4'h0);
    step();
    check("d6_rd0",    {224'd0, bus6.rdata}, {224'd0, 32'h0000CAFE});
    check("d6_rd0_ae", {254'd0, bus6.ack, bus6.err}, 256'd2);
    drive6(1'b1, 1'b0, 3'd7, 32'h0, 4'h0);
    step();
    check("d6_rd7_ae",  {254'd0, bus6.ack, bus6.err}, 256'd3);
    check("d6_rd7_dat", {224'd0, bus6.rdata}, 256'd0);
    drive6(1'b1, 1'b1, 3'd6, 32'hFFFFFFFF, 4'hF);
    step();
    check("d6_wr6_ae",   {254'd0, bus6.ack, bus6.err}, 256'd3);
    check("d6_wr6_dout", {64'd0, d_out6}, flat6());
    drive6(1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
    step();
    check("d6_idle_ae", {254'd0, bus6.ack, bus6.err}, 256'd0);

    // Asynchronous reset in the middle of activity
    drive8(1'b1, 1'b1, 3'd4, 32'h00001234, 4'hF);
    step();
    drive8(1'b1, 1'b0, 3'd4, 32'h0, 4'h0);
    step();
    check("pre_rst_rd", {224'd0, bus8.rdata}, {224'd0, 32'h00001234});
    clr8 = 1'b1;
    drive8(1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
    step();
    clr8 = 1'b0;
    step();
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_busy",  {255'd0, busy8}, 256'd0);
    check("ar_ack",   {254'd0, bus8.ack, bus8.err}, 256'd0);
    check("ar_rdata", {224'd0, bus8.rdata}, 256'd0);
    check("ar_dout",  d_out8, 256'd0);
    check("ar_dout6", {64'd0, d_out6}, 256'd0);
    check("ar_rd6",   {224'd0, bus6.rdata}, 256'd0);
    step();
    reset_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
